// File: rtl/serial2tcp_loopback_fifo_if.sv
// Stream bundle between the serial2tcp bridge and the loopback FIFO.
// Sink side:   serial2tcp_sink_valid/ready/data    (bridge -> FIFO)
// Source side: serial2tcp_source_valid/ready/data  (FIFO -> fabric)
// Modport slave is the FIFO's view. Modport master is the view of the
// environment, which drives the sink beats and the source back-pressure.
interface serial2tcp_loopback_fifo_if #(
    parameter int DATA_W = 8
);
    logic              serial2tcp_sink_valid;
    logic              serial2tcp_sink_ready;
    logic [DATA_W-1:0] serial2tcp_sink_data;
    logic              serial2tcp_source_valid;
    logic              serial2tcp_source_ready;
    logic [DATA_W-1:0] serial2tcp_source_data;

    modport master (
        output serial2tcp_sink_valid,
        output serial2tcp_sink_data,
        output serial2tcp_source_ready,
        input  serial2tcp_sink_ready,
        input  serial2tcp_source_valid,
        input  serial2tcp_source_data
    );

    modport slave (
        input  serial2tcp_sink_valid,
        input  serial2tcp_sink_data,
        input  serial2tcp_source_ready,
        output serial2tcp_sink_ready,
        output serial2tcp_source_valid,
        output serial2tcp_source_data
    );
endinterface

// File: rtl/serial2tcp_loopback_fifo.sv
// Loopback and test endpoint for the serial2tcp bridge. Beats accepted on
// the sink side are optionally transformed, buffered in a DEPTH-entry FIFO
// and returned on the source side. Free-running beat counters let the host
// check the link.
// Ports:
//   sys_clk, sys_rst_n : clock (rising edge), async active-low reset
//   s2t                : sink/source valid-ready-data streams (slave view)
//   mode               : 0 pass, 1 invert, 2 increment, 3 pass
//   flush              : synchronous FIFO clear (counters kept)
//   level              : current occupancy, 0..DEPTH
//   rx_count, tx_count : wrapping counts of accepted / delivered beats
module serial2tcp_loopback_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    serial2tcp_loopback_fifo_if.slave  s2t,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           rx_count,
    output logic [CNT_W-1:0]           tx_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_INC  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rdy_en;   // low in reset, high from the first edge after release
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_data;

    // Ready depends only on registered state and flush, never on source_ready.
    assign s2t.serial2tcp_sink_ready   = rdy_en & (level < LVL_W'(DEPTH)) & ~flush;
    assign s2t.serial2tcp_source_valid = (level != '0);
    // Force zero when empty so the output is defined in reset and after flush.
    assign s2t.serial2tcp_source_data  = s2t.serial2tcp_source_valid ? mem[rd_ptr] : '0;

    // sink_ready already carries ~flush; pop needs it explicitly so a beat
    // presented during a flush is neither consumed nor counted.
    assign push = s2t.serial2tcp_sink_valid & s2t.serial2tcp_sink_ready;
    assign pop  = s2t.serial2tcp_source_valid & s2t.serial2tcp_source_ready & ~flush;

    // The transform is applied on the way in, so later mode changes leave
    // stored beats alone.
    // NOTE: every always_comb output gets a default first, otherwise an
    // uncovered path holds its old value and a latch is inferred.
    always_comb begin
        wr_data = s2t.serial2tcp_sink_data;
        case (mode_e'(mode))
            MODE_INV: wr_data = ~s2t.serial2tcp_sink_data;
            MODE_INC: wr_data = s2t.serial2tcp_sink_data + DATA_W'(1);
            default:  wr_data = s2t.serial2tcp_sink_data;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdy_en   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: level <= level;
                endcase
            end
            if (push) rx_count <= rx_count + 1'b1;
            if (pop)  tx_count <= tx_count + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; level gates visibility, and
    // leaving it out of reset lets it map onto plain RAM/flops without reset.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule
